// File: rtl/lpc_model_store.sv
// Levinson-Durbin coefficient store: two registered read ports, paired write-back,
// per-order commit of km, and a valid/ready dump of model[1..order] to the quantiser.
module lpc_model_store #(
  parameter int unsigned ORDER_MAX = 12,
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 4
) (
  input  logic          iClock,
  input  logic          iReset,
  input  logic          iInit,
  input  logic [AW-1:0] iSel1,
  input  logic [AW-1:0] iSel2,
  output logic [DW-1:0] oModel1,
  output logic [DW-1:0] oModel2,
  input  logic          iWrValid,
  input  logic          iOnlyOne,
  input  logic [AW-1:0] iTarget1,
  input  logic [AW-1:0] iTarget2,
  input  logic [DW-1:0] iNewModel1,
  input  logic [DW-1:0] iNewModel2,
  input  logic          iCommit,
  input  logic [AW-1:0] iM,
  input  logic [DW-1:0] iKm,
  input  logic          iDumpStart,
  output logic [DW-1:0] oRdData,
  output logic [AW-1:0] oRdIndex,
  output logic          oRdValid,
  output logic          oRdLast,
  input  logic          iRdReady,
  output logic [AW-1:0] oOrder,
  output logic          oBusy,
  output logic          oError
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_DUMP   = 2'd2;

  localparam logic [DW-1:0] ONE_F   = DW'(32'h3f800000);
  localparam logic [AW-1:0] MAX_IDX = AW'(ORDER_MAX);

  logic [1:0]    state;
  logic [DW-1:0] model [0:ORDER_MAX];

  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [AW-1:0] nxt_idx;
  logic [DW-1:0] nxt_data;
  logic          commit_ok;

  always_comb begin
    rd1 = '0;
    if (iSel1 <= MAX_IDX) rd1 = model[iSel1];
  end

  always_comb begin
    rd2 = '0;
    if (iSel2 <= MAX_IDX) rd2 = model[iSel2];
  end

  always_comb begin
    nxt_idx  = oRdIndex + AW'(1);
    nxt_data = '0;
    if (nxt_idx <= MAX_IDX) nxt_data = model[nxt_idx];
  end

  // A commit must extend the model by exactly one order.
  assign commit_ok = (iM == oOrder + AW'(1)) && (iM != '0) && (iM <= MAX_IDX);

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      for (int unsigned i = 0; i <= ORDER_MAX; i++)
        model[i] <= (i == 0) ? ONE_F : '0;
      state    <= S_IDLE;
      oModel1  <= '0;
      oModel2  <= '0;
      oRdData  <= '0;
      oRdIndex <= '0;
      oRdValid <= 1'b0;
      oRdLast  <= 1'b0;
      oOrder   <= '0;
      oBusy    <= 1'b0;
      oError   <= 1'b0;
    end else begin
      // Reads see pre-write contents and run in every state, including iInit cycles.
      oModel1 <= rd1;
      oModel2 <= rd2;
      if (iInit) begin
        for (int unsigned i = 0; i <= ORDER_MAX; i++)
          model[i] <= (i == 0) ? ONE_F : '0;
        state    <= S_IDLE;
        oRdData  <= '0;
        oRdIndex <= '0;
        oRdValid <= 1'b0;
        oRdLast  <= 1'b0;
        oOrder   <= '0;
        oBusy    <= 1'b0;
        oError   <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_UPDATE: begin
            // Entry 0 is never written; per entry: commit, then target1, then target2.
            for (int unsigned i = 1; i <= ORDER_MAX; i++) begin
              if (iCommit && commit_ok && (iM == AW'(i)))
                model[i] <= iKm;
              else if (iWrValid && (iTarget1 == AW'(i)))
                model[i] <= iNewModel1;
              else if (iWrValid && !iOnlyOne && (iTarget2 == AW'(i)))
                model[i] <= iNewModel2;
            end
            if (iCommit) begin
              if (commit_ok) oOrder <= iM;
              else           oError <= 1'b1;
            end
            if (iDumpStart) begin
              if (oOrder == '0) begin
                oError <= 1'b1;
                state  <= S_IDLE;
              end else begin
                state    <= S_DUMP;
                oBusy    <= 1'b1;
                oRdValid <= 1'b1;
                oRdIndex <= AW'(1);
                oRdData  <= model[1];
                oRdLast  <= (oOrder == AW'(1));
              end
            end else if (iCommit || iWrValid) begin
              state <= S_UPDATE;
            end
          end
          S_DUMP: begin
            if (iWrValid || iCommit) oError <= 1'b1;
            if (oRdValid && iRdReady) begin
              if (oRdLast) begin
                oRdValid <= 1'b0;
                oRdLast  <= 1'b0;
                oBusy    <= 1'b0;
                state    <= S_IDLE;
              end else begin
                oRdIndex <= nxt_idx;
                oRdData  <= nxt_data;
                oRdLast  <= (nxt_idx == oOrder);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_model_store.sv
// Scoreboard bench for lpc_model_store: stimulus queues expected read/stream data,
// independent monitors compare whenever the DUT presents a result.
module tb_lpc_model_store;

  localparam int unsigned ORDER_MAX = 12;
  localparam int unsigned DW        = 32;
  localparam int unsigned AW        = 4;

  localparam logic [DW-1:0] ONE_F = 32'h3f800000;
  localparam logic [DW-1:0] K1    = 32'hbf7f7cee;
  localparam logic [DW-1:0] K2    = 32'h3f6be0df;
  localparam logic [DW-1:0] K3    = 32'h3eb95810;

  logic          iClock, iReset, iInit;
  logic [AW-1:0] iSel1, iSel2;
  logic [DW-1:0] oModel1, oModel2;
  logic          iWrValid, iOnlyOne;
  logic [AW-1:0] iTarget1, iTarget2;
  logic [DW-1:0] iNewModel1, iNewModel2;
  logic          iCommit;
  logic [AW-1:0] iM;
  logic [DW-1:0] iKm;
  logic          iDumpStart;
  logic [DW-1:0] oRdData;
  logic [AW-1:0] oRdIndex;
  logic          oRdValid, oRdLast, iRdReady;
  logic [AW-1:0] oOrder;
  logic          oBusy, oError;

  lpc_model_store #(.ORDER_MAX(ORDER_MAX), .DW(DW), .AW(AW)) dut (
    .iClock(iClock), .iReset(iReset), .iInit(iInit),
    .iSel1(iSel1), .iSel2(iSel2), .oModel1(oModel1), .oModel2(oModel2),
    .iWrValid(iWrValid), .iOnlyOne(iOnlyOne), .iTarget1(iTarget1), .iTarget2(iTarget2),
    .iNewModel1(iNewModel1), .iNewModel2(iNewModel2),
    .iCommit(iCommit), .iM(iM), .iKm(iKm),
    .iDumpStart(iDumpStart), .oRdData(oRdData), .oRdIndex(oRdIndex),
    .oRdValid(oRdValid), .oRdLast(oRdLast), .iRdReady(iRdReady),
    .oOrder(oOrder), .oBusy(oBusy), .oError(oError)
  );

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  beat_t         qb[$];
  logic          rd1_en = 1'b0;
  logic          rd2_en = 1'b0;

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read-port monitor: a read captured at a posedge is compared at the following negedge.
  initial begin
    forever begin
      logic e1, e2;
      @(posedge iClock);
      e1 = rd1_en;
      e2 = rd2_en;
      @(negedge iClock);
      if (e1) begin
        if (q1.size() == 0) begin n_vec++; n_err++; $display("FAIL model1: no expectation queued"); end
        else check("model1", 64'(oModel1), 64'(q1.pop_front()));
      end
      if (e2) begin
        if (q2.size() == 0) begin n_vec++; n_err++; $display("FAIL model2: no expectation queued"); end
        else check("model2", 64'(oModel2), 64'(q2.pop_front()));
      end
    end
  end

  // Stream monitor: every presented beat is compared (stalled beats repeatedly); popped on accept.
  initial begin
    forever begin
      @(negedge iClock);
      if (iReset && oRdValid) begin
        if (qb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL beat: unexpected beat idx %0d data %h", oRdIndex, oRdData);
        end else begin
          check("beat", 64'({oRdIndex, oRdData, oRdLast}), 64'(qb[0]));
          if (iRdReady) void'(qb.pop_front());
        end
      end
    end
  end

  task automatic set_rd(input logic [AW-1:0] s1, input logic [DW-1:0] e1,
                        input logic [AW-1:0] s2, input logic [DW-1:0] e2);
    iSel1 = s1; iSel2 = s2; rd1_en = 1'b1; rd2_en = 1'b1;
    q1.push_back(e1); q2.push_back(e2);
  endtask

  task automatic set_wr(input logic oo, input logic [AW-1:0] t1, input logic [AW-1:0] t2,
                        input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    iWrValid = 1'b1; iOnlyOne = oo; iTarget1 = t1; iTarget2 = t2;
    iNewModel1 = d1; iNewModel2 = d2;
  endtask

  task automatic set_commit(input logic [AW-1:0] m, input logic [DW-1:0] km);
    iCommit = 1'b1; iM = m; iKm = km;
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
    iWrValid = 1'b0; iCommit = 1'b0; iInit = 1'b0; iDumpStart = 1'b0;
    rd1_en = 1'b0; rd2_en = 1'b0;
  endtask

  initial begin
    iReset = 1'b0; iInit = 1'b0; iSel1 = '0; iSel2 = '0;
    iWrValid = 1'b0; iOnlyOne = 1'b0; iTarget1 = '0; iTarget2 = '0;
    iNewModel1 = '0; iNewModel2 = '0; iCommit = 1'b0; iM = '0; iKm = '0;
    iDumpStart = 1'b0; iRdReady = 1'b0;

    repeat (2) @(posedge iClock);
    #1;
    check("rst_model1", 64'(oModel1), 64'(0));
    check("rst_order",  64'(oOrder),  64'(0));
    check("rst_error",  64'(oError),  64'(0));
    check("rst_valid",  64'(oRdValid), 64'(0));
    check("rst_busy",   64'(oBusy),   64'(0));
    iReset = 1'b1;

    set_rd(0, ONE_F, 5, 0); step();
    check("order0", 64'(oOrder), 64'(0));
    check("error0", 64'(oError), 64'(0));

    set_commit(1, K1); step();
    check("order1", 64'(oOrder), 64'(1));
    set_rd(1, K1, 3, 0); step();
    set_commit(3, 32'h12345678); step();
    check("bad_commit_err",   64'(oError), 64'(1));
    check("bad_commit_order", 64'(oOrder), 64'(1));
    set_rd(3, 0, 13, 0); step();

    set_wr(0, 1, 1, 32'h11111111, 32'h22222222); step();
    set_rd(1, 32'h11111111, 0, ONE_F); step();
    set_wr(1, 3, 2, 32'h33333333, 32'h44444444); step();
    set_rd(2, 0, 3, 32'h33333333); step();
    set_wr(0, 0, 4, 32'h55555555, 32'h66666666); step();
    set_rd(0, ONE_F, 4, 32'h66666666); step();

    set_wr(1, 1, 0, 32'h77777777, 0);
    set_rd(1, 32'h11111111, 15, 0); step();
    set_rd(1, 32'h77777777, 2, 0); step();

    iInit = 1'b1; step();
    check("init_order", 64'(oOrder), 64'(0));
    check("init_error", 64'(oError), 64'(0));
    set_rd(1, 0, 0, ONE_F); step();

    set_commit(1, K1); step();
    set_commit(2, K2); step();
    set_commit(3, K3); step();
    check("order3", 64'(oOrder), 64'(3));
    check("order3_err", 64'(oError), 64'(0));
    qb.push_back('{idx: 4'd1, data: K1, last: 1'b0});
    qb.push_back('{idx: 4'd2, data: K2, last: 1'b0});
    qb.push_back('{idx: 4'd3, data: K3, last: 1'b1});
    iRdReady = 1'b0; iDumpStart = 1'b1; step();
    check("dump_busy", 64'(oBusy), 64'(1));
    begin
      logic [3:0] pat;
      pat = 4'b1101;
      for (int i = 3; i >= 0; i--) begin
        iRdReady = pat[i];
        step();
      end
    end
    check("dump_end_valid", 64'(oRdValid), 64'(0));
    check("dump_end_busy",  64'(oBusy),    64'(0));
    check("dump_beats_left", 64'(qb.size()), 64'(0));
    iRdReady = 1'b0;
    set_wr(1, 5, 0, 32'haaaa5555, 0); step();
    set_rd(5, 32'haaaa5555, 3, K3); step();
    check("post_dump_err", 64'(oError), 64'(0));

    iInit = 1'b1; step();
    iDumpStart = 1'b1; step();
    check("dump0_err",   64'(oError),   64'(1));
    check("dump0_busy",  64'(oBusy),    64'(0));
    check("dump0_valid", 64'(oRdValid), 64'(0));

    iInit = 1'b1; step();
    set_commit(1, K1); step();
    set_commit(2, K2); step();
    qb.push_back('{idx: 4'd1, data: K1, last: 1'b0});
    iRdReady = 1'b0; iDumpStart = 1'b1; step();
    set_wr(0, 1, 2, 32'h99999999, 32'h88888888); step();
    check("dump_wr_err", 64'(oError), 64'(1));
    set_rd(1, K1, 2, K2); iInit = 1'b1; step();
    check("init_dump_valid", 64'(oRdValid), 64'(0));
    check("init_dump_busy",  64'(oBusy),    64'(0));
    check("init_dump_order", 64'(oOrder),   64'(0));
    check("init_dump_err",   64'(oError),   64'(0));
    qb.delete();
    set_rd(1, 0, 2, 0); step();

    set_commit(1, K1); step();
    set_wr(1, 2, 0, 32'h0badf00d, 0); step();
    set_rd(1, K1, 2, 32'h0badf00d); step();
    @(negedge iClock);
    #1;
    iReset = 1'b0;
    #1;
    check("arst_model1", 64'(oModel1),  64'(0));
    check("arst_order",  64'(oOrder),   64'(0));
    check("arst_valid",  64'(oRdValid), 64'(0));
    @(posedge iClock);
    #1;
    iReset = 1'b1;
    set_rd(1, 0, 2, 0); step();
    set_rd(0, ONE_F, 12, 0); step();

    step();
    check("q1_left", 64'(q1.size()), 64'(0));
    check("q2_left", 64'(q2.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
